// File: rtl/bufswap.sv
// Double-buffer bank controller: SPI words land in the back bank, scanout reads
// the front bank, and the banks swap only at a scanout frame boundary after a full SPI frame.
module bufswap #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int OVR_W  = 8
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              spi_ss,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_clk,
  input  logic [ADDR_W-1:0] scan_raddr,
  input  logic              scan_frame_start,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_raddr,
  output logic              front,
  output logic              swap_pending,
  output logic              swapped,
  output logic [OVR_W-1:0]  overrun_cnt
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_e;

  state_e state_q, state_d;

  // chip-select synchronizer and edge detect
  logic ss_meta, ss_sync, ss_prev;
  logic ss_rise, ss_fall;

  // word strobe edge detect and capture stage
  logic              wr_clk_q;
  logic              word_event;
  logic              accept;
  logic              drop;
  logic              cap_valid;
  logic              cap_bank;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  logic [ADDR_W:0]   words_q;
  logic              drop_frame;
  logic              do_swap;

  // spi_ss is asynchronous to sysclk; the idle (deselected) level is the reset value
  // so that leaving reset never looks like an edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta <= 1'b1;
      ss_sync <= 1'b1;
      ss_prev <= 1'b1;
    end else begin
      // NOTE: every sequential assignment uses <= so the three stages shift
      // together; a blocking = here would collapse the chain into one flop.
      ss_meta <= spi_ss;
      ss_sync <= ss_meta;
      ss_prev <= ss_sync;
    end
  end

  assign ss_rise = ss_sync & ~ss_prev;
  assign ss_fall = ~ss_sync & ss_prev;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) wr_clk_q <= 1'b0;
    else        wr_clk_q <= wr_clk;
  end

  assign word_event = wr_clk & ~wr_clk_q;
  assign accept     = word_event && (state_q == FILL) && !drop_frame;
  assign drop       = word_event && !accept;

  // Bank bit is frozen at capture so a swap between capture and write cannot
  // redirect an accepted word into the displayed bank.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_bank  <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
    end else begin
      cap_valid <= accept;
      if (accept) begin
        cap_bank <= ~front;
        cap_addr <= wr_addr;
        cap_data <= wr_data;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= cap_valid;
      if (cap_valid) begin
        ram_waddr <= {cap_bank, cap_addr};
        ram_wdata <= cap_data;
      end
    end
  end

  // Bank controller FSM: state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Bank controller FSM: next state and swap decision
  always_comb begin
    // NOTE: defaults first so no path leaves state_d or do_swap unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    do_swap = 1'b0;
    unique case (state_q)
      FILL: begin
        // a frame boundary arriving with ss_rise is deliberately not used
        if (ss_rise && (words_q != '0)) state_d = PENDING;
      end
      PENDING: begin
        if (scan_frame_start) begin
          do_swap = 1'b1;
          state_d = SWAP;
        end
      end
      SWAP:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  assign swap_pending = (state_q == PENDING);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      front   <= 1'b0;
      swapped <= 1'b0;
    end else begin
      swapped <= do_swap;
      if (do_swap) front <= ~front;
    end
  end

  assign ram_raddr = {front, scan_raddr};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
    end else if (do_swap) begin
      words_q <= '0;
    end else if (accept && (words_q != '1)) begin
      words_q <= words_q + 1'b1;
    end
  end

  // Once a frame starts overrunning, the rest of it is discarded until the
  // next chip-select assertion, even if a swap happens in between.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_frame <= 1'b0;
    end else if (drop) begin
      drop_frame <= 1'b1;
    end else if (ss_fall) begin
      drop_frame <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (drop && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bufswap.sv
// Bench for bufswap: directed table of SPI/scanout operations, hand-written
// corner sequences, then random operations checked against a frame-level model.
module tb_bufswap;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int OVR_W  = 8;

  logic              sysclk;
  logic              rst_n;
  logic              spi_ss;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_clk;
  logic [ADDR_W-1:0] scan_raddr;
  logic              scan_frame_start;
  logic [ADDR_W:0]   ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [ADDR_W:0]   ram_raddr;
  logic              front;
  logic              swap_pending;
  logic              swapped;
  logic [OVR_W-1:0]  overrun_cnt;

  bufswap #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OVR_W(OVR_W)) dut (
    .sysclk           (sysclk),
    .rst_n            (rst_n),
    .spi_ss           (spi_ss),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_clk           (wr_clk),
    .scan_raddr       (scan_raddr),
    .scan_frame_start (scan_frame_start),
    .ram_waddr        (ram_waddr),
    .ram_wdata        (ram_wdata),
    .ram_we           (ram_we),
    .ram_raddr        (ram_raddr),
    .front            (front),
    .swap_pending     (swap_pending),
    .swapped          (swapped),
    .overrun_cnt      (overrun_cnt)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef enum int {OP_FALL, OP_RISE, OP_WORD, OP_FS} op_e;

  typedef struct {
    op_e         op;
    logic [11:0] addr;
    logic [31:0] data;
    logic        exp_front;
    logic        exp_pend;
    int          exp_ovr;
    logic        exp_wr;
    logic [12:0] exp_waddr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // observed RAM writes {waddr, wdata} and swapped pulses
  logic [44:0] wq[$];
  int          sw_cnt = 0;

  always @(posedge sysclk) begin
    #1;
    if (ram_we === 1'b1) wq.push_back({ram_waddr, ram_wdata});
    if (swapped === 1'b1) sw_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic apply_op(input op_e op, input logic [11:0] addr, input logic [31:0] data,
                          input int hold);
    case (op)
      OP_FALL: begin spi_ss = 1'b0; tick(6); end
      OP_RISE: begin spi_ss = 1'b1; tick(6); end
      OP_WORD: begin
        wr_addr = addr;
        wr_data = data;
        wr_clk  = 1'b1;
        tick(hold);
        wr_clk  = 1'b0;
        tick(3);
      end
      default: begin
        scan_frame_start = 1'b1;
        tick(1);
        scan_frame_start = 1'b0;
        tick(3);
      end
    endcase
  endtask

  function automatic vec_t mk(op_e op, int addr, int data, bit f, bit p, int o, bit w, int wa);
    vec_t v;
    v.op        = op;
    v.addr      = 12'(addr);
    v.data      = 32'(data);
    v.exp_front = f;
    v.exp_pend  = p;
    v.exp_ovr   = o;
    v.exp_wr    = w;
    v.exp_waddr = 13'(wa);
    return v;
  endfunction

  vec_t vecs[$];

  // frame-level reference model state
  bit          m_front, m_pend, m_drop, m_ss;
  int          m_words, m_ovr, m_sw;
  logic [44:0] m_q[$];

  initial begin
    logic  prev_front;
    int    sw0;
    logic [44:0] got, exp;

    rst_n = 1'b0;
    spi_ss = 1'b1;
    wr_addr = '0;
    wr_data = '0;
    wr_clk = 1'b0;
    scan_raddr = '0;
    scan_frame_start = 1'b0;

    #2;
    check("reset_front", front, 0);
    check("reset_pending", swap_pending, 0);
    check("reset_swapped", swapped, 0);
    check("reset_we", ram_we, 0);
    check("reset_waddr", ram_waddr, 0);
    check("reset_wdata", ram_wdata, 0);
    check("reset_ovr", overrun_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // empty frame: no words -> no pending, no swap
    vecs.push_back(mk(OP_FALL, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_RISE, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FS,   0, 0, 0, 0, 0, 0, 0));
    // three-word frame into bank 1, then swap
    vecs.push_back(mk(OP_FALL, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WORD, 0, 'hA, 0, 0, 0, 1, 'h1000));
    vecs.push_back(mk(OP_WORD, 1, 'hB, 0, 0, 0, 1, 'h1001));
    vecs.push_back(mk(OP_WORD, 2, 'hC, 0, 0, 0, 1, 'h1002));
    vecs.push_back(mk(OP_RISE, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(OP_FS,   0, 0, 1, 0, 0, 0, 0));
    // one-word frame into bank 0, swap back to front=0
    vecs.push_back(mk(OP_FALL, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WORD, 7, 'h77, 1, 0, 0, 1, 'h0007));
    vecs.push_back(mk(OP_RISE, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(OP_FS,   0, 0, 0, 0, 0, 0, 0));
    // frame pending, next frame overruns, stays dropped across the swap
    vecs.push_back(mk(OP_FALL, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_WORD, 3, 'h33, 0, 0, 0, 1, 'h1003));
    vecs.push_back(mk(OP_RISE, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(OP_FALL, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(OP_WORD, 'h10 + i, 'h100 + i, 0, 1, i + 1, 0, 0));
    vecs.push_back(mk(OP_FS,   0, 0, 1, 0, 5, 0, 0));
    vecs.push_back(mk(OP_WORD, 'h20, 'h200, 1, 0, 6, 0, 0));
    vecs.push_back(mk(OP_RISE, 0, 0, 1, 0, 6, 0, 0));
    vecs.push_back(mk(OP_FALL, 0, 0, 1, 0, 6, 0, 0));
    vecs.push_back(mk(OP_WORD, 9, 'h99, 1, 0, 6, 1, 'h0009));
    vecs.push_back(mk(OP_RISE, 0, 0, 1, 1, 6, 0, 0));
    vecs.push_back(mk(OP_FS,   0, 0, 0, 0, 6, 0, 0));

    prev_front = 1'b0;
    foreach (vecs[i]) begin
      sw0 = sw_cnt;
      wq.delete();
      scan_raddr = 12'($urandom);
      apply_op(vecs[i].op, vecs[i].addr, vecs[i].data, 1 + (i % 3));
      check($sformatf("vec%0d_front", i), front, vecs[i].exp_front);
      check($sformatf("vec%0d_pending", i), swap_pending, vecs[i].exp_pend);
      check($sformatf("vec%0d_ovr", i), overrun_cnt, vecs[i].exp_ovr);
      check($sformatf("vec%0d_raddr", i), ram_raddr, {vecs[i].exp_front, scan_raddr});
      check($sformatf("vec%0d_swaps", i), sw_cnt - sw0, (vecs[i].exp_front != prev_front) ? 1 : 0);
      check($sformatf("vec%0d_wr_count", i), wq.size(), vecs[i].exp_wr ? 1 : 0);
      if (vecs[i].exp_wr && wq.size() > 0)
        check($sformatf("vec%0d_write", i), wq[0], {vecs[i].exp_waddr, vecs[i].data});
      prev_front = vecs[i].exp_front;
    end

    // ss_rise and scan_frame_start in the same cycle: pending, no swap yet
    apply_op(OP_FALL, 0, 0, 1);
    wq.delete();
    apply_op(OP_WORD, 'h40, 'h4040, 1);
    check("coinc_write", wq.size() > 0 ? wq[0] : 45'd0, {13'h1040, 32'h4040});
    sw0 = sw_cnt;
    spi_ss = 1'b1;
    tick(2);
    scan_frame_start = 1'b1;
    tick(1);
    scan_frame_start = 1'b0;
    tick(4);
    check("coinc_pending", swap_pending, 1);
    check("coinc_front", front, 0);
    check("coinc_swaps", sw_cnt - sw0, 0);
    apply_op(OP_FS, 0, 0, 1);
    check("coinc_next_front", front, 1);
    check("coinc_next_swaps", sw_cnt - sw0, 1);

    // wr_clk held high for 10 cycles -> one write
    apply_op(OP_FALL, 0, 0, 1);
    wq.delete();
    apply_op(OP_WORD, 'h55, 'h5555, 10);
    check("held_wr_count", wq.size(), 1);
    check("held_write", wq.size() > 0 ? wq[0] : 45'd0, {13'h0055, 32'h5555});
    check("held_ovr", overrun_cnt, 6);

    // 300 dropped words while pending -> saturated counter
    apply_op(OP_RISE, 0, 0, 1);
    check("sat_pending", swap_pending, 1);
    apply_op(OP_FALL, 0, 0, 1);
    wq.delete();
    for (int i = 0; i < 300; i++) begin
      wr_addr = 12'(i);
      wr_clk = 1'b1;
      tick(1);
      wr_clk = 1'b0;
      tick(1);
    end
    tick(3);
    check("sat_ovr", overrun_cnt, 255);
    check("sat_wr_count", wq.size(), 0);
    check("sat_front", front, 1);

    // asynchronous reset while pending with front=1
    check("prerst_pending", swap_pending, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_front", front, 0);
    check("arst_pending", swap_pending, 0);
    check("arst_we", ram_we, 0);
    check("arst_waddr", ram_waddr, 0);
    check("arst_ovr", overrun_cnt, 0);
    check("arst_raddr_msb", ram_raddr[ADDR_W], 0);
    tick(2);
    spi_ss = 1'b1;
    rst_n = 1'b1;
    tick(3);
    check("postrst_pending", swap_pending, 0);

    // random operations against the frame-level model
    m_front = 0; m_pend = 0; m_drop = 0; m_ss = 1;
    m_words = 0; m_ovr = 0; m_sw = 0;
    m_q.delete();
    wq.delete();
    sw0 = sw_cnt;
    for (int n = 0; n < 250; n++) begin
      int r;
      op_e op;
      logic [11:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      op = (r < 50) ? OP_WORD : (r < 65) ? OP_FALL : (r < 80) ? OP_RISE : OP_FS;
      a = 12'($urandom);
      d = $urandom;
      case (op)
        OP_WORD: begin
          if (!m_pend && !m_drop) begin
            m_q.push_back({~m_front, a, d});
            m_words++;
          end else begin
            m_drop = 1;
            if (m_ovr < 255) m_ovr++;
          end
        end
        OP_FALL: begin
          if (m_ss) m_drop = 0;
          m_ss = 0;
        end
        OP_RISE: begin
          if (!m_ss && !m_pend && m_words > 0) m_pend = 1;
          m_ss = 1;
        end
        default: begin
          if (m_pend) begin
            m_front = ~m_front;
            m_pend = 0;
            m_words = 0;
            m_sw++;
          end
        end
      endcase
      scan_raddr = 12'($urandom);
      apply_op(op, a, d, $urandom_range(1, 3));
      check($sformatf("rnd%0d_front", n), front, m_front);
      check($sformatf("rnd%0d_pending", n), swap_pending, m_pend);
      check($sformatf("rnd%0d_ovr", n), overrun_cnt, m_ovr);
      check($sformatf("rnd%0d_raddr", n), ram_raddr, {m_front, scan_raddr});
      check($sformatf("rnd%0d_swaps", n), sw_cnt - sw0, m_sw);
      check($sformatf("rnd%0d_wr_count", n), wq.size(), m_q.size());
      while (wq.size() > 0 && m_q.size() > 0) begin
        got = wq.pop_front();
        exp = m_q.pop_front();
        check($sformatf("rnd%0d_write", n), got, exp);
      end
      wq.delete();
      m_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
